// File: rtl/cnn_pkg.sv
// Shared types and helpers for the streaming convolution/pooling engine.
package cnn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWload,
    StFeed,
    StDrain
  } state_e;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Clamp a wide signed value into the range of a dw-bit signed word.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] value,
                                                input int unsigned        dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/pool2x2_unit.sv
// 2x2 stride-2 max/average pooling over a raster stream of convolution results.
module pool2x2_unit
  import cnn_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 4,
  parameter int unsigned P  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 conv_valid,
  input  logic signed [DW-1:0] conv_data,
  input  logic [CW-1:0]        conv_row,
  input  logic [CW-1:0]        conv_col,
  input  logic                 flush,
  output logic                 pool_valid,
  output logic signed [DW-1:0] pool_data,
  output logic                 pool_last
);

  localparam int unsigned SW = DW + 2;
  localparam int unsigned BW = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] EdgeIdx = CW'(2 * P - 1);

  logic signed [DW-1:0] first_q;
  logic signed [SW-1:0] pair_buf_q [P];
  logic signed [DW-1:0] hold_q;
  logic                 valid_q;
  logic signed [DW-1:0] data_q;
  logic                 last_q;

  logic                 in_range;
  logic                 pair_done;
  logic                 quad_done;
  logic                 is_final;
  logic [BW-1:0]        slot;
  logic signed [SW-1:0] conv_ext;
  logic signed [SW-1:0] first_ext;
  logic signed [SW-1:0] pair;
  logic signed [SW-1:0] stored;
  logic signed [DW-1:0] quad;

  always_comb begin
    // Odd conv sides leave a trailing row/column that never joins a block.
    in_range  = (conv_row <= EdgeIdx) && (conv_col <= EdgeIdx);
    pair_done = conv_valid && in_range && conv_col[0];
    quad_done = pair_done && conv_row[0];
    is_final  = quad_done && (conv_row == EdgeIdx) && (conv_col == EdgeIdx);
    slot      = BW'(conv_col >> 1);
    conv_ext  = SW'(conv_data);
    first_ext = SW'(first_q);
    stored    = pair_buf_q[slot];
    if (mode == POOL_AVG) begin
      pair = first_ext + conv_ext;
      quad = DW'((stored + pair) >>> 2);
    end else begin
      pair = (first_ext > conv_ext) ? first_ext : conv_ext;
      quad = (stored > pair) ? DW'(stored) : DW'(pair);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q    <= '0;
      pair_buf_q <= '{default: '0};
      hold_q     <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      if (conv_valid && in_range && !conv_col[0]) begin
        first_q <= conv_data;
      end
      if (pair_done && !conv_row[0]) begin
        pair_buf_q[slot] <= pair;
      end
      // The final block is held back so it leaves together with the end-of-frame marker.
      if (is_final) begin
        hold_q <= quad;
      end
      valid_q <= (quad_done && !is_final) || flush;
      last_q  <= flush;
      if (flush) begin
        data_q <= is_final ? quad : hold_q;
      end else if (quad_done) begin
        data_q <= quad;
      end
    end
  end

  assign pool_valid = valid_q;
  assign pool_data  = data_q;
  assign pool_last  = last_q;

endmodule

// File: rtl/conv_pool_stream.sv
// Streaming 3x3 fixed-point convolution over an internally zero-padded raster image,
// followed by 2x2 stride-2 max/average pooling.
module conv_pool_stream
  import cnn_pkg::*;
#(
  parameter int unsigned DW   = 16,
  parameter int unsigned IMG  = 7,
  parameter int unsigned PAD  = 1,
  parameter int unsigned FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_load,
  input  logic                 w_valid,
  input  logic signed [DW-1:0] w_data,
  input  logic                 start,
  input  logic                 relu_en,
  input  logic                 pool_mode,
  input  logic                 img_valid,
  input  logic signed [DW-1:0] img_data,
  output logic                 img_ready,
  output logic                 pool_valid,
  output logic signed [DW-1:0] pool_data,
  output logic                 pool_last,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned SIZE = IMG + 2 * PAD;
  localparam int unsigned O    = SIZE - 2;
  localparam int unsigned P    = O / 2;
  localparam int unsigned CW   = $clog2(SIZE);
  localparam int unsigned ACCW = 2 * DW + 4;
  localparam logic [CW-1:0] LastIdx = CW'(SIZE - 1);

  state_e               state_q, state_d;
  logic [3:0]           wcnt_q;
  logic                 drain_q;
  logic                 relu_q;
  logic                 mode_q;
  logic [CW-1:0]        row_q;
  logic [CW-1:0]        col_q;
  logic signed [DW-1:0] weight_q [9];
  logic signed [DW-1:0] lb0_q [SIZE];
  logic signed [DW-1:0] lb1_q [SIZE];
  logic signed [DW-1:0] win_q [3][3];
  logic signed [DW-1:0] win_d [3][3];
  logic                 conv_valid_q;
  logic signed [DW-1:0] conv_data_q;
  logic [CW-1:0]        conv_row_q;
  logic [CW-1:0]        conv_col_q;

  logic                   is_pad;
  logic                   take;
  logic                   last_pos;
  logic                   conv_hit;
  logic                   w_take;
  logic                   accept_wload;
  logic                   accept_start;
  logic                   flush;
  logic signed [DW-1:0]   pix;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_shr;
  logic signed [DW-1:0]   conv_d;

  always_comb begin
    is_pad = (32'(row_q) < PAD) || (32'(row_q) >= SIZE - PAD) ||
             (32'(col_q) < PAD) || (32'(col_q) >= SIZE - PAD);
    accept_wload = (state_q == StIdle) && w_load;
    accept_start = (state_q == StIdle) && !w_load && start;
    w_take       = (state_q == StWload) && w_valid;
    take         = (state_q == StFeed) && (is_pad || img_valid);
    last_pos     = (row_q == LastIdx) && (col_q == LastIdx);
    conv_hit     = take && (row_q >= CW'(2)) && (col_q >= CW'(2));
    flush        = (state_q == StDrain) && !drain_q;

    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept_wload) begin
          state_d = StWload;
        end else if (accept_start) begin
          state_d = StFeed;
        end
      end
      StWload: if (w_take && (wcnt_q == 4'd8)) state_d = StIdle;
      StFeed:  if (take && last_pos) state_d = StDrain;
      StDrain: if (drain_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign img_ready = (state_q == StFeed) && !is_pad;
  assign busy      = (state_q != StIdle);

  // The MAC sees the window as it will be after this position shifts in,
  // so the registered result lands one cycle after the take.
  always_comb begin
    pix = is_pad ? '0 : img_data;
    for (int i = 0; i < 3; i++) begin
      win_d[2'(i)][0] = win_q[2'(i)][1];
      win_d[2'(i)][1] = win_q[2'(i)][2];
    end
    win_d[0][2] = lb1_q[col_q];
    win_d[1][2] = lb0_q[col_q];
    win_d[2][2] = pix;

    acc = '0;
    for (int k = 0; k < 9; k++) begin
      prod = weight_q[4'(k)] * win_d[2'(k / 3)][2'(k % 3)];
      acc  = acc + ACCW'(prod);
    end
    acc_shr = acc >>> FRAC;
    conv_d  = DW'(sat_dw(64'(acc_shr), DW));
    if (relu_q && conv_d[DW-1]) begin
      conv_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wcnt_q       <= '0;
      drain_q      <= 1'b0;
      relu_q       <= 1'b0;
      mode_q       <= POOL_MAX;
      row_q        <= '0;
      col_q        <= '0;
      weight_q     <= '{default: '0};
      lb0_q        <= '{default: '0};
      lb1_q        <= '{default: '0};
      win_q        <= '{default: '0};
      conv_valid_q <= 1'b0;
      conv_data_q  <= '0;
      conv_row_q   <= '0;
      conv_col_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == StDrain) && !drain_q;

      if (accept_wload) begin
        wcnt_q <= '0;
      end else if (w_take) begin
        wcnt_q <= wcnt_q + 4'd1;
        for (int k = 0; k < 8; k++) begin
          weight_q[4'(k)] <= weight_q[4'(k + 1)];
        end
        weight_q[8] <= w_data;
      end

      if (accept_start) begin
        relu_q <= relu_en;
        mode_q <= pool_mode;
      end

      // Counters wrap to zero after the last padded position, ready for the next frame.
      if (take) begin
        lb1_q[col_q] <= lb0_q[col_q];
        lb0_q[col_q] <= pix;
        win_q        <= win_d;
        if (col_q == LastIdx) begin
          col_q <= '0;
          row_q <= (row_q == LastIdx) ? '0 : row_q + CW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end

      conv_valid_q <= conv_hit;
      if (conv_hit) begin
        conv_data_q <= conv_d;
        conv_row_q  <= row_q - CW'(2);
        conv_col_q  <= col_q - CW'(2);
      end
    end
  end

  pool2x2_unit #(
    .DW (DW),
    .CW (CW),
    .P  (P)
  ) u_pool (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode_q),
    .conv_valid (conv_valid_q),
    .conv_data  (conv_data_q),
    .conv_row   (conv_row_q),
    .conv_col   (conv_col_q),
    .flush      (flush),
    .pool_valid (pool_valid),
    .pool_data  (pool_data),
    .pool_last  (pool_last)
  );

  assign frame_done = pool_last;

endmodule

// File: tb/tb_conv_pool_stream.sv
// Directed and randomized frames for conv_pool_stream against a plain-arithmetic model.
module tb_conv_pool_stream;

  localparam int DW   = 16;
  localparam int IMG  = 7;
  localparam int PAD  = 1;
  localparam int FRAC = 8;
  localparam int SIZE = IMG + 2 * PAD;
  localparam int O    = SIZE - 2;
  localparam int P    = O / 2;
  localparam int NPIX = IMG * IMG;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 w_load;
  logic                 w_valid;
  logic signed [DW-1:0] w_data;
  logic                 start;
  logic                 relu_en;
  logic                 pool_mode;
  logic                 img_valid;
  logic signed [DW-1:0] img_data;
  logic                 img_ready;
  logic                 pool_valid;
  logic signed [DW-1:0] pool_data;
  logic                 pool_last;
  logic                 busy;
  logic                 frame_done;

  int     checks   = 0;
  int     failures = 0;
  int     img_px [IMG][IMG];
  int     wts [9];
  longint exp_q [$];

  always #5 clk = ~clk;

  conv_pool_stream #(
    .DW   (DW),
    .IMG  (IMG),
    .PAD  (PAD),
    .FRAC (FRAC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .w_load     (w_load),
    .w_valid    (w_valid),
    .w_data     (w_data),
    .start      (start),
    .relu_en    (relu_en),
    .pool_mode  (pool_mode),
    .img_valid  (img_valid),
    .img_data   (img_data),
    .img_ready  (img_ready),
    .pool_valid (pool_valid),
    .pool_data  (pool_data),
    .pool_last  (pool_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint padded(input int r, input int c);
    if (r < PAD || r >= PAD + IMG || c < PAD || c >= PAD + IMG) return 0;
    return longint'(img_px[r - PAD][c - PAD]);
  endfunction

  task automatic build_expected(input bit relu, input bit avg);
    longint cv [O][O];
    longint s, a, b, c, d, m;
    longint hi, lo;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    exp_q.delete();
    for (int i = 0; i < O; i++) begin
      for (int j = 0; j < O; j++) begin
        s = 0;
        for (int u = 0; u < 3; u++)
          for (int v = 0; v < 3; v++) s += longint'(wts[u * 3 + v]) * padded(i + u, j + v);
        s = s >>> FRAC;
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        if (relu && s < 0) s = 0;
        cv[i][j] = s;
      end
    end
    for (int pr = 0; pr < P; pr++) begin
      for (int pc = 0; pc < P; pc++) begin
        a = cv[2 * pr][2 * pc];
        b = cv[2 * pr][2 * pc + 1];
        c = cv[2 * pr + 1][2 * pc];
        d = cv[2 * pr + 1][2 * pc + 1];
        if (avg) begin
          m = (a + b + c + d) >>> 2;
        end else begin
          m = a;
          if (b > m) m = b;
          if (c > m) m = c;
          if (d > m) m = d;
        end
        exp_q.push_back(m);
      end
    end
  endtask

  task automatic load_weights(input bit gaps, input bit also_start);
    int k;
    w_load = 1'b1;
    start  = also_start;
    tick();
    w_load = 1'b0;
    k = 0;
    while (k < 9) begin
      w_valid = !gaps || ($urandom_range(0, 1) == 1);
      w_data  = 16'(wts[k]);
      start   = also_start && (k == 3);
      tick();
      if (w_valid) k++;
    end
    w_valid = 1'b0;
    start   = 1'b0;
    @(negedge clk);
    chk("wload_idle_busy", busy, 0);
    chk("wload_idle_ready", img_ready, 0);
    tick();
  endtask

  task automatic run_frame(input string tag, input bit relu, input bit avg, input bit gaps,
                           input bit poke_wload);
    int     idx, pads, k;
    bit     done, poke;
    longint got [$];
    bit     lst [$];
    build_expected(relu, avg);
    relu_en   = relu;
    pool_mode = avg;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    relu_en   = !relu;
    pool_mode = !avg;
    idx = 0;
    pads = 0;
    k = 0;
    done = 1'b0;
    while (!done && k < 1000) begin
      k++;
      img_valid = (idx < NPIX) && (!gaps || (k % 2 == 1));
      img_data  = (idx < NPIX) ? 16'(img_px[idx / IMG][idx % IMG]) : '0;
      poke      = poke_wload && k >= 10 && k < 22;
      w_load    = poke;
      w_valid   = poke;
      w_data    = poke ? 16'($urandom) : '0;
      @(negedge clk);
      if (img_valid && img_ready) idx++;
      if (!img_ready) pads++;
      if (pool_valid) begin
        got.push_back(longint'(pool_data));
        lst.push_back(pool_last);
      end
      if (frame_done) done = 1'b1;
      else tick();
    end
    img_valid = 1'b0;
    w_load    = 1'b0;
    w_valid   = 1'b0;
    chk({tag, "/done"}, done, 1);
    if (!gaps) chk({tag, "/cycles"}, k, 83);
    chk({tag, "/pad_cycles"}, pads, 34);
    chk({tag, "/accepted"}, idx, NPIX);
    chk({tag, "/count"}, got.size(), P * P);
    for (int i = 0; i < P * P; i++) begin
      chk($sformatf("%s/res%0d", tag, i), (i < got.size()) ? got[i] : -999999, exp_q[i]);
      chk($sformatf("%s/last%0d", tag, i), (i < lst.size()) ? lst[i] : 0, (i == P * P - 1));
    end
    @(negedge clk);
    chk({tag, "/busy_fall"}, busy, 0);
    tick();
  endtask

  task automatic set_identity();
    foreach (wts[k]) wts[k] = 0;
    wts[4] = 256;
  endtask

  task automatic set_raster();
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++) img_px[r][c] = r * IMG + c;
  endtask

  initial begin
    int hs, k;
    rst = 1'b1;
    w_load = 1'b0;
    w_valid = 1'b0;
    w_data = '0;
    start = 1'b0;
    relu_en = 1'b0;
    pool_mode = 1'b0;
    img_valid = 1'b0;
    img_data = '0;
    repeat (3) tick();
    chk("rst_pool_valid", pool_valid, 0);
    chk("rst_pool_data", pool_data, 0);
    chk("rst_pool_last", pool_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_img_ready", img_ready, 0);
    rst = 1'b0;
    tick();

    // Identity kernel on a ramp, max pooling.
    set_identity();
    set_raster();
    load_weights(1'b0, 1'b0);
    run_frame("ident_max", 1'b0, 1'b0, 1'b0, 1'b0);

    // Stalled input must give the same results.
    run_frame("ident_gaps", 1'b0, 1'b0, 1'b1, 1'b0);

    // w_load during FEED is ignored.
    run_frame("ident_wpoke", 1'b0, 1'b0, 1'b0, 1'b1);

    // All 256 weights, flat image of 4, average pooling.
    foreach (wts[i]) wts[i] = 256;
    foreach (img_px[r, c]) img_px[r][c] = 4;
    load_weights(1'b1, 1'b0);
    run_frame("flat_avg", 1'b0, 1'b1, 1'b0, 1'b0);

    // Saturation at the positive rail.
    foreach (wts[i]) wts[i] = 32767;
    foreach (img_px[r, c]) img_px[r][c] = 32767;
    load_weights(1'b0, 1'b0);
    run_frame("sat_max", 1'b0, 1'b0, 1'b0, 1'b0);

    // ReLU clamps negatives; start coincident with and during the load is dropped.
    set_identity();
    foreach (img_px[r, c]) img_px[r][c] = -5;
    load_weights(1'b0, 1'b1);
    run_frame("relu_neg", 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("norelu_neg", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset after 20 accepted pixels.
    set_raster();
    start = 1'b1;
    tick();
    start = 1'b0;
    hs = 0;
    k = 0;
    while (hs < 20 && k < 200) begin
      k++;
      img_valid = 1'b1;
      img_data  = 16'(img_px[hs / IMG][hs % IMG]);
      @(negedge clk);
      if (img_ready) hs++;
      tick();
    end
    img_valid = 1'b0;
    chk("midrst_accepted", hs, 20);
    rst = 1'b1;
    tick();
    chk("midrst_pool_valid", pool_valid, 0);
    chk("midrst_pool_data", pool_data, 0);
    chk("midrst_pool_last", pool_last, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_img_ready", img_ready, 0);
    rst = 1'b0;
    tick();

    // Weights were cleared by reset.
    foreach (wts[i]) wts[i] = 0;
    run_frame("midrst_wzero", 1'b0, 1'b0, 1'b0, 1'b0);

    set_identity();
    load_weights(1'b0, 1'b0);
    run_frame("midrst_rerun", 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized kernels, images and modes.
    for (int n = 0; n < 3; n++) begin
      foreach (wts[i]) wts[i] = int'($urandom_range(0, 1023)) - 512;
      foreach (img_px[r, c]) img_px[r][c] = int'($urandom_range(0, 65535)) - 32768;
      load_weights(1'b1, 1'b0);
      run_frame($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
